// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch front end of the lanzones core. Issues single-beat read
// requests to instruction memory, buffers the returned words together with
// their PCs in a small FIFO, and presents the FIFO head to decode through a
// valid/ready handshake. A redirect from execute flushes the buffer, retargets
// the PC and marks any in-flight fetch as stale.
//
// Ports:
//   clk       core clock, all state updates on the rising edge
//   rstn      asynchronous reset, active-high despite the name
//   LEn       fetch enable, 0 stops new requests
//   RedirVld  redirect strobe from execute
//   RedirPc   redirect target PC
//   RRdy      memory read request strobe (one cycle per request)
//   RAddr     memory read address, valid while RRdy is high
//   RVld      memory read data valid
//   RData     memory read data
//   IVld      instruction valid to decode
//   IRdy      decode ready
//   IData     instruction word at FIFO head
//   IPc       PC of the instruction at FIFO head
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        LEn,
    input  logic        RedirVld,
    input  logic [31:0] RedirPc,
    output logic        RRdy,
    output logic [31:0] RAddr,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        IVld,
    input  logic        IRdy,
    output logic [31:0] IData,
    output logic [31:0] IPc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state_q;
    logic [31:0]   pc_q;
    logic [31:0]   reqPc_q;
    logic [31:0]   raddr_q;
    logic          rrdy_q;
    logic          discard_q;

    logic [31:0]   dataMem_q [FIFO_DEPTH];
    logic [31:0]   pcMem_q   [FIFO_DEPTH];
    logic [AW-1:0] rdPtr_q;
    logic [AW-1:0] wrPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          respTaken;
    logic          push;
    logic          pop;
    logic          issue;

    // Per-cycle events. The issue decision looks at the FIFO occupancy after
    // this cycle's push/pop and at whether the single request slot frees up
    // this cycle, so a response and the next request can share one edge.
    // Because the outstanding request always has a reserved slot, a push
    // can never find the FIFO full.
    always_comb begin
        respTaken = (state_q == WAIT) && RVld;
        push      = respTaken && !discard_q && !RedirVld;
        pop       = (count_q != '0) && IRdy && !RedirVld;
        count_d   = count_q;
        if (RedirVld) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
        issue = ((state_q == IDLE) || respTaken) && LEn && !RedirVld
                && (count_d < DEPTH_C);
    end

    // Fetch FSM, request outputs and FIFO storage. A redirect overrides every
    // other event: the buffer is emptied, the PC retargeted, and an in-flight
    // request whose data has not yet arrived is marked for discard so the
    // stale word never reaches decode.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            reqPc_q   <= '0;
            raddr_q   <= '0;
            rrdy_q    <= 1'b0;
            discard_q <= 1'b0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dataMem_q[i] <= '0;
                pcMem_q[i]   <= '0;
            end
        end else begin
            rrdy_q  <= issue;
            count_q <= count_d;

            if (RedirVld) begin
                pc_q    <= RedirPc;
                rdPtr_q <= wrPtr_q;
                if ((state_q == WAIT) && !RVld) begin
                    discard_q <= 1'b1;
                end else begin
                    state_q   <= IDLE;
                    discard_q <= 1'b0;
                end
            end else begin
                if (respTaken) begin
                    state_q   <= IDLE;
                    discard_q <= 1'b0;
                end
                if (issue) begin
                    raddr_q <= pc_q;
                    reqPc_q <= pc_q;
                    pc_q    <= pc_q + PC_STEP;
                    state_q <= WAIT;
                end
                if (push) begin
                    dataMem_q[wrPtr_q] <= RData;
                    pcMem_q[wrPtr_q]   <= reqPc_q;
                    wrPtr_q            <= wrPtr_q + AW'(1);
                end
                if (pop) begin
                    rdPtr_q <= rdPtr_q + AW'(1);
                end
            end
        end
    end

    assign RRdy  = rrdy_q;
    assign RAddr = raddr_q;
    assign IVld  = (count_q != '0);
    assign IData = dataMem_q[rdPtr_q];
    assign IPc   = pcMem_q[rdPtr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A behavioural model keeps a queue of
// the words decode should see, the next expected fetch address and the state
// of the single in-flight request; the memory responder lives in the same
// per-cycle loop and answers with a programmable latency.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        LEn;
    logic        RedirVld;
    logic [31:0] RedirPc;
    logic        RRdy;
    logic [31:0] RAddr;
    logic        RVld;
    logic [31:0] RData;
    logic        IVld;
    logic        IRdy;
    logic [31:0] IData;
    logic [31:0] IPc;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .PC_STEP   (32'd1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .LEn     (LEn),
        .RedirVld(RedirVld),
        .RedirPc (RedirPc),
        .RRdy    (RRdy),
        .RAddr   (RAddr),
        .RVld    (RVld),
        .RData   (RData),
        .IVld    (IVld),
        .IRdy    (IRdy),
        .IData   (IData),
        .IPc     (IPc)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    int          errors = 0;
    int          checks = 0;

    entry_t      q[$];
    bit          outstanding;
    bit          stale;
    bit          expRRdy;
    bit          justIssued;
    logic [31:0] inflightAddr;
    logic [31:0] nextFetchPc;
    logic [31:0] lastAddr;
    int          cd;
    int          reqCount;

    int          latMax   = 1;
    int          irdyPct  = 100;
    int          lenPct   = 100;
    int          redirPct = 0;
    int          spurPct  = 0;
    bit          forceRedir;
    bit          forceIRdy;
    logic [31:0] forcePc;

    // Instruction memory contents: the first four words are fixed, the rest
    // is a hash of the address so every location is distinguishable.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a < 32'd4) return 32'h11 * (a + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of what happens at the coming clock edge given the inputs just
    // driven: decode consumes the head, a returning word is buffered unless
    // it is stale or a redirect lands, and a redirect empties the buffer.
    task automatic modelEdge();
        if ((q.size() > 0) && IRdy && !RedirVld) void'(q.pop_front());
        if (RVld && outstanding) begin
            if (!stale && !RedirVld) q.push_back('{memWord(inflightAddr), inflightAddr});
            outstanding = 0;
            stale       = 0;
        end
        if (RedirVld) begin
            q.delete();
            nextFetchPc = RedirPc;
            if (outstanding) stale = 1;
        end
        expRRdy = LEn && !RedirVld && !outstanding && (q.size() < DEPTH);
    endtask

    // Compare registered outputs of the current cycle with the model.
    task automatic checkOutput();
        justIssued = 0;
        check32("RRdy", {31'b0, RRdy}, {31'b0, expRRdy});
        if (RRdy === 1'b1) begin
            check32("RAddr", RAddr, nextFetchPc);
            lastAddr     = nextFetchPc;
            reqCount++;
            outstanding  = 1;
            stale        = 0;
            inflightAddr = nextFetchPc;
            nextFetchPc  = nextFetchPc + 32'd1;
            cd           = int'($urandom_range(latMax, 1));
            justIssued   = 1;
        end
        check32("IVld", {31'b0, IVld}, {31'b0, (q.size() != 0)});
        if (q.size() != 0) begin
            check32("IData", IData, q[0].data);
            check32("IPc", IPc, q[0].pc);
        end
    endtask

    // Drive inputs for the current cycle, including the memory response.
    task automatic applyStimulus();
        LEn      = (int'($urandom_range(99, 0)) < lenPct);
        IRdy     = forceIRdy ? 1'b1 : (int'($urandom_range(99, 0)) < irdyPct);
        RedirVld = forceRedir || (int'($urandom_range(99, 0)) < redirPct);
        RedirPc  = forceRedir ? forcePc : 32'($urandom);
        forceRedir = 0;
        forceIRdy  = 0;
        RVld  = 1'b0;
        RData = 32'($urandom);
        if (outstanding && !justIssued) begin
            cd--;
            if (cd == 0) begin
                RVld  = 1'b1;
                RData = memWord(inflightAddr);
            end
        end else if (!outstanding && (int'($urandom_range(99, 0)) < spurPct)) begin
            RVld = 1'b1;
        end
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1;
        checkOutput();
        applyStimulus();
        modelEdge();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    // Runs until a request has just been seen with exactly one word already
    // buffered; an expired budget counts as a failed check.
    task automatic waitReqWithOne(input string tag);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            runCycle();
            found = justIssued && (q.size() == 1);
        end
        check32(tag, {31'b0, found}, 32'd1);
    endtask

    // Reset pulse asserted between clock edges while a request is in flight.
    task automatic midReset();
        #2;
        rstn = 1'b1;
        #1;
        check32("rst_RRdy", {31'b0, RRdy}, 32'd0);
        check32("rst_IVld", {31'b0, IVld}, 32'd0);
        check32("rst_RAddr", RAddr, 32'd0);
        check32("rst_IData", IData, 32'd0);
        check32("rst_IPc", IPc, 32'd0);
        LEn = 0; RVld = 0; RedirVld = 0; IRdy = 0;
        @(posedge clk);
        #3;
        rstn  = 1'b0;
        LEn   = 1'b1;
        IRdy  = 1'b1;
        RVld  = 1'b1;
        RData = 32'hDEAD_BEEF;
        q.delete();
        outstanding = 0;
        stale       = 0;
        nextFetchPc = RESET_PC;
        modelEdge();
    endtask

    initial begin
        bit found;

        rstn = 1'b1;
        LEn = 0; RedirVld = 0; RedirPc = '0; RVld = 0; RData = '0; IRdy = 0;
        outstanding = 0; stale = 0; expRRdy = 0; reqCount = 0;
        forceRedir = 0; forceIRdy = 0; forcePc = '0;
        nextFetchPc = RESET_PC;
        #1;
        check32("init_RRdy", {31'b0, RRdy}, 32'd0);
        check32("init_RAddr", RAddr, 32'd0);
        check32("init_IVld", {31'b0, IVld}, 32'd0);
        check32("init_IData", IData, 32'd0);
        check32("init_IPc", IPc, 32'd0);

        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b0;
        LEn  = 1'b1;
        IRdy = 1'b1;
        modelEdge();

        // Streaming with one-cycle latency: a request every other cycle.
        runCycles(9);
        check32("stream_reqs", reqCount, 32'd5);
        runCycles(4);

        // Backpressure: exactly DEPTH requests, then fetching stalls.
        irdyPct    = 0;
        forceRedir = 1;
        forcePc    = 32'd0;
        runCycle();
        reqCount = 0;
        runCycles(12);
        check32("bp_reqs", reqCount, 32'd2);
        check32("bp_IData", IData, 32'h11);
        check32("bp_IPc", IPc, 32'd0);
        irdyPct = 100;

        // Redirect in the cycle after the request for address 2.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            runCycle();
            found = justIssued && (lastAddr == 32'd2);
        end
        check32("wait_req2", {31'b0, found}, 32'd1);
        forceRedir = 1;
        forcePc    = 32'h40;
        runCycle();
        runCycles(10);

        // Redirect with a buffered word, a pop and a returning word together.
        irdyPct    = 0;
        forceRedir = 1;
        forcePc    = 32'h80;
        runCycle();
        waitReqWithOne("wait_full4");
        forceRedir = 1;
        forcePc    = 32'h100;
        forceIRdy  = 1;
        runCycle();
        irdyPct = 100;
        runCycles(8);

        // Asynchronous reset while waiting for a response.
        irdyPct    = 0;
        forceRedir = 1;
        forcePc    = 32'h200;
        runCycle();
        waitReqWithOne("wait_rst5");
        midReset();
        irdyPct = 100;
        runCycles(8);

        // PC wrap at the top of the address space.
        forceRedir = 1;
        forcePc    = 32'hFFFF_FFFF;
        runCycle();
        runCycles(10);

        // Randomised traffic: variable latency, stalls, redirects, stray RVld.
        latMax   = 3;
        irdyPct  = 60;
        lenPct   = 85;
        redirPct = 4;
        spurPct  = 10;
        runCycles(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
